// File: rtl/cv32e40p_recovery_ctrl.sv
// Restore sequencer for a faulted cv32e40p core: setback, register-file replay from the
// checkpoint RF, then PC/CSR recovery, finishing with a one-cycle done pulse.
module cv32e40p_recovery_ctrl #(
    parameter int unsigned FPU_RF         = 0,
    parameter int unsigned SETBACK_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        setback_o,
    output logic        recover_o,
    output logic [5:0]  backup_raddr_a_o,
    output logic [5:0]  backup_raddr_b_o,
    input  logic [31:0] backup_rdata_a_i,
    input  logic [31:0] backup_rdata_b_i,
    output logic        regfile_we_a_o,
    output logic [5:0]  regfile_waddr_a_o,
    output logic [31:0] regfile_wdata_a_o,
    output logic        regfile_we_b_o,
    output logic [5:0]  regfile_waddr_b_o,
    output logic [31:0] regfile_wdata_b_o,
    input  logic [31:0] backup_program_counter_i,
    input  logic        backup_branch_i,
    input  logic [31:0] backup_branch_addr_i,
    input  logic [6:0]  backup_mstatus_i,
    input  logic [31:0] backup_mie_i,
    input  logic [23:0] backup_mtvec_i,
    input  logic [31:0] backup_mscratch_i,
    input  logic [31:0] backup_mip_i,
    input  logic [31:0] backup_mepc_i,
    input  logic [5:0]  backup_mcause_i,
    output logic        pc_recover_o,
    output logic [31:0] recovery_program_counter_o,
    output logic        recovery_branch_o,
    output logic [31:0] recovery_branch_addr_o,
    output logic [6:0]  recovery_mstatus_o,
    output logic [31:0] recovery_mie_o,
    output logic [23:0] recovery_mtvec_o,
    output logic [31:0] recovery_mscratch_o,
    output logic [31:0] recovery_mip_o,
    output logic [31:0] recovery_mepc_o,
    output logic [5:0]  recovery_mcause_o
);

    localparam logic [5:0] LastAddr = (FPU_RF != 0) ? 6'd63 : 6'd31;
    localparam logic [5:0] LastPair = LastAddr - 6'd2;
    localparam logic [3:0] SbLoad   = 4'(SETBACK_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetback,
        StRfRead,
        StRfDrain,
        StPc,
        StDone
    } state_e;

    state_e     state_q;
    logic [3:0] sb_cnt_q;
    logic       we_a_q;
    logic       we_b_q;
    logic [5:0] waddr_a_q;
    logic [5:0] waddr_b_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q                    <= StIdle;
            sb_cnt_q                   <= 4'd0;
            busy_o                     <= 1'b0;
            done_o                     <= 1'b0;
            setback_o                  <= 1'b0;
            recover_o                  <= 1'b0;
            pc_recover_o               <= 1'b0;
            backup_raddr_a_o           <= 6'd0;
            backup_raddr_b_o           <= 6'd0;
            we_a_q                     <= 1'b0;
            we_b_q                     <= 1'b0;
            waddr_a_q                  <= 6'd0;
            waddr_b_q                  <= 6'd0;
            recovery_program_counter_o <= 32'd0;
            recovery_branch_o          <= 1'b0;
            recovery_branch_addr_o     <= 32'd0;
            recovery_mstatus_o         <= 7'd0;
            recovery_mie_o             <= 32'd0;
            recovery_mtvec_o           <= 24'd0;
            recovery_mscratch_o        <= 32'd0;
            recovery_mip_o             <= 32'd0;
            recovery_mepc_o            <= 32'd0;
            recovery_mcause_o          <= 6'd0;
        end else begin
            // Write stage replays last cycle's read address; data arrives with 1-cycle latency.
            we_a_q    <= (state_q == StRfRead);
            we_b_q    <= (state_q == StRfRead) && (backup_raddr_b_o != 6'd0);
            waddr_a_q <= (state_q == StRfRead) ? backup_raddr_a_o : 6'd0;
            waddr_b_q <= (state_q == StRfRead) ? backup_raddr_b_o : 6'd0;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q                    <= StSetback;
                        busy_o                     <= 1'b1;
                        setback_o                  <= 1'b1;
                        sb_cnt_q                   <= SbLoad;
                        recovery_program_counter_o <= backup_program_counter_i;
                        recovery_branch_o          <= backup_branch_i;
                        recovery_branch_addr_o     <= backup_branch_addr_i;
                        recovery_mstatus_o         <= backup_mstatus_i;
                        recovery_mie_o             <= backup_mie_i;
                        recovery_mtvec_o           <= backup_mtvec_i;
                        recovery_mscratch_o        <= backup_mscratch_i;
                        recovery_mip_o             <= backup_mip_i;
                        recovery_mepc_o            <= backup_mepc_i;
                        recovery_mcause_o          <= backup_mcause_i;
                    end
                end
                StSetback: begin
                    if (sb_cnt_q == 4'd0) begin
                        state_q          <= StRfRead;
                        setback_o        <= 1'b0;
                        recover_o        <= 1'b1;
                        backup_raddr_a_o <= 6'd1;
                        backup_raddr_b_o <= 6'd2;
                    end else begin
                        sb_cnt_q <= sb_cnt_q - 4'd1;
                    end
                end
                StRfRead: begin
                    if (backup_raddr_a_o == LastAddr) begin
                        state_q          <= StRfDrain;
                        backup_raddr_a_o <= 6'd0;
                        backup_raddr_b_o <= 6'd0;
                    end else if (backup_raddr_a_o == LastPair) begin
                        // Odd register count: the top register is read alone.
                        backup_raddr_a_o <= LastAddr;
                        backup_raddr_b_o <= 6'd0;
                    end else begin
                        backup_raddr_a_o <= backup_raddr_a_o + 6'd2;
                        backup_raddr_b_o <= backup_raddr_b_o + 6'd2;
                    end
                end
                StRfDrain: begin
                    state_q      <= StPc;
                    pc_recover_o <= 1'b1;
                end
                StPc: begin
                    state_q      <= StDone;
                    pc_recover_o <= 1'b0;
                    recover_o    <= 1'b0;
                    done_o       <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign regfile_we_a_o    = we_a_q;
    assign regfile_waddr_a_o = waddr_a_q;
    assign regfile_wdata_a_o = we_a_q ? backup_rdata_a_i : 32'd0;
    assign regfile_we_b_o    = we_b_q;
    assign regfile_waddr_b_o = waddr_b_q;
    assign regfile_wdata_b_o = we_b_q ? backup_rdata_b_i : 32'd0;

    // x0 is hardwired in the core and must never appear on a recovery write port.
    a_no_x0_a: assert property (@(posedge clk_i) disable iff (rst_i)
        regfile_we_a_o |-> (regfile_waddr_a_o != 6'd0));
    a_no_x0_b: assert property (@(posedge clk_i) disable iff (rst_i)
        regfile_we_b_o |-> (regfile_waddr_b_o != 6'd0));
    a_done_once: assert property (@(posedge clk_i) disable iff (rst_i)
        done_o |=> !done_o);

endmodule
